mio_bus_ctrl: RTL and testbench

//  Memory/IO bus controller downstream of the multicycle CPU control FSM.

---
 rtl/mio_bus_ctrl.sv | 118 +++++++++++
 tb/tb_mio_bus_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: decodes CPU memory/IO requests to RAM, GPIO or counter and sequences each access with RAM wait states
module mio_bus_ctrl #(
    parameter int RAM_WAIT = 2,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       gpio_in,
    output logic [31:0]       gpio_out,
    output logic              cnt_we,
    input  logic [31:0]       cnt_val
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic [1:0] {R_RAM, R_GPIO, R_CNT, R_NONE} region_t;

    localparam logic [3:0] WAIT_INIT = 4'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);

    state_t            state_q;
    region_t           region_q, region_d;
    logic              wr_q;
    logic [3:0]        wcnt_q;
    logic [31:0]       rdata_q, gpio_out_q, ram_wdata_q, rd_data_d;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              mio_ready_q, bus_err_q, ram_we_q, cnt_we_q, legal_d;
    logic              unused_addr;

    assign unused_addr = ^{addr[27:RAM_AW+2], addr[1:0]};

    // An illegal request is steered to the unmapped region so it runs the normal error path
    always_comb begin
        legal_d   = mem_read ^ mem_write;
        region_d  = !legal_d              ? R_NONE :
                    addr[31:28] == 4'h0   ? R_RAM  :
                    addr[31:28] == 4'hE   ? R_GPIO :
                    addr[31:28] == 4'hF   ? R_CNT  : R_NONE;
        rd_data_d = wr_q                  ? 32'h0            :
                    region_q == R_RAM     ? ram_rdata        :
                    region_q == R_GPIO    ? {16'h0, gpio_in} :
                    region_q == R_CNT     ? cnt_val          : 32'h0;
    end

    // Transaction sequencer; every output is a register set on the edge entering its state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            region_q    <= R_NONE;
            wr_q        <= 1'b0;
            wcnt_q      <= 4'h0;
            rdata_q     <= 32'h0;
            gpio_out_q  <= 32'h0;
            ram_wdata_q <= 32'h0;
            ram_addr_q  <= '0;
            mio_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            cnt_we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cpu_mio) begin
                    state_q     <= ACCESS;
                    region_q    <= region_d;
                    wr_q        <= mem_write;
                    ram_addr_q  <= addr[RAM_AW+1:2];
                    ram_wdata_q <= wdata;
                    ram_we_q    <= mem_write && region_d == R_RAM;
                    cnt_we_q    <= mem_write && region_d == R_CNT;
                    if (!legal_d) bus_err_q <= 1'b1;
                end
                ACCESS: begin
                    ram_we_q <= 1'b0;
                    cnt_we_q <= 1'b0;
                    if (wr_q && region_q == R_GPIO) gpio_out_q <= ram_wdata_q;
                    if (region_q == R_NONE) bus_err_q <= 1'b1;
                    if (region_q == R_RAM && RAM_WAIT > 0) begin
                        state_q <= WAIT;
                        wcnt_q  <= WAIT_INIT;
                    end else begin
                        state_q     <= DONE;
                        mio_ready_q <= 1'b1;
                        rdata_q     <= rd_data_d;
                    end
                end
                WAIT: if (wcnt_q == 4'h0) begin
                    state_q     <= DONE;
                    mio_ready_q <= 1'b1;
                    rdata_q     <= rd_data_d;
                end else begin
                    wcnt_q <= wcnt_q - 4'h1;
                end
                DONE: begin
                    state_q     <= IDLE;
                    mio_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign mio_ready = mio_ready_q;
    assign bus_err   = bus_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign gpio_out  = gpio_out_q;
    assign cnt_we    = cnt_we_q;
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: randomized check of mio_bus_ctrl against a transaction-level reference model
module tb_mio_bus_ctrl;
    localparam int W0 = 2;

    logic        clk = 1'b0, reset = 1'b1, mem_clr = 1'b1;
    logic        cpu_mio0 = 1'b0, cpu_mio1 = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = '0, wdata = '0, cnt_val = '0;
    logic [15:0] gpio_in = '0;

    logic [31:0] rdata0, ram_wdata0, ram_rdata0, gpio_out0;
    logic [31:0] rdata1, ram_wdata1, ram_rdata1, gpio_out1;
    logic [9:0]  ram_addr0, ram_addr1;
    logic        mio_ready0, bus_err0, ram_we0, cnt_we0;
    logic        mio_ready1, bus_err1, ram_we1, cnt_we1;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_gpio = '0;
    logic        ref_err = 1'b0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mio_bus_ctrl #(.RAM_WAIT(W0), .RAM_AW(10)) u0 (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio0), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .mio_ready(mio_ready0), .bus_err(bus_err0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we(ram_we0), .ram_rdata(ram_rdata0),
        .gpio_in(gpio_in), .gpio_out(gpio_out0), .cnt_we(cnt_we0), .cnt_val(cnt_val)
    );

    mio_bus_ctrl #(.RAM_WAIT(0), .RAM_AW(10)) u1 (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio1), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .mio_ready(mio_ready1), .bus_err(bus_err1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1),
        .gpio_in(gpio_in), .gpio_out(gpio_out1), .cnt_we(cnt_we1), .cnt_val(cnt_val)
    );

    assign ram_rdata0 = mem[ram_addr0];
    assign ram_rdata1 = mem[ram_addr1];

    // Bench RAM shared by both controllers
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (ram_we0) mem[ram_addr0] <= ram_wdata0;
            if (ram_we1) mem[ram_addr1] <= ram_wdata1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request on controller sel (0: RAM_WAIT=2, 1: RAM_WAIT=0), checked against the model
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  rg;
        bit          legal, mapped, exp_we, exp_cw;
        int          lat, got_lat, nwe, ncw;
        logic [31:0] exp_rd;
        rg      = a[31:28];
        legal   = rd ^ wr;
        mapped  = rg == 4'h0 || rg == 4'hE || rg == 4'hF;
        lat     = (legal && rg == 4'h0) ? 2 + (sel ? 0 : W0) : 2;
        exp_rd  = !(legal && rd) ? 32'h0 :
                  rg == 4'h0 ? ref_mem[a[11:2]] :
                  rg == 4'hE ? {16'h0, gpio_in} :
                  rg == 4'hF ? cnt_val : 32'h0;
        exp_we  = legal && wr && rg == 4'h0;
        exp_cw  = legal && wr && rg == 4'hF;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        if (sel) cpu_mio1 = 1'b1; else cpu_mio0 = 1'b1;
        got_lat = 0; nwe = 0; ncw = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (sel ? ram_we1 : ram_we0) begin
                nwe++;
                check("ram_addr", {22'h0, sel ? ram_addr1 : ram_addr0}, {22'h0, a[11:2]});
                check("ram_wdata", sel ? ram_wdata1 : ram_wdata0, d);
            end
            if (sel ? cnt_we1 : cnt_we0) begin
                ncw++;
                check("cnt_data", sel ? ram_wdata1 : ram_wdata0, d);
            end
            if (sel ? mio_ready1 : mio_ready0) begin
                got_lat = n;
                break;
            end
        end
        cpu_mio0 = 1'b0; cpu_mio1 = 1'b0;
        if (exp_we) ref_mem[a[11:2]] = d;
        if (legal && wr && rg == 4'hE) ref_gpio = d;
        if (!legal || !mapped) ref_err = 1'b1;
        check("latency", got_lat, lat);
        check("rdata", sel ? rdata1 : rdata0, exp_rd);
        check("ram_we_count", nwe, {31'h0, exp_we});
        check("cnt_we_count", ncw, {31'h0, exp_cw});
        if (!sel) begin
            check("gpio_out", gpio_out0, ref_gpio);
            check("bus_err", {31'h0, bus_err0}, {31'h0, ref_err});
        end
    endtask

    initial begin
        logic [5:0]  pulses;
        logic [3:0]  rg;
        int          r, op, events;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_ready", {31'h0, mio_ready0}, 32'h0);
        check("rst_err", {31'h0, bus_err0}, 32'h0);
        check("rst_gpio", gpio_out0, 32'h0);
        check("rst_strobes", {30'h0, ram_we0, cnt_we0}, 32'h0);
        check("rst_ram_addr", {22'h0, ram_addr0}, 32'h0);
        reset = 1'b0; mem_clr = 1'b0;

        txn(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        txn(0, 1, 0, 32'h0000_0010, 32'h0);
        gpio_in = 16'hA5A5;
        txn(0, 1, 0, 32'hE000_0000, 32'h0);
        txn(0, 0, 1, 32'hE000_0000, 32'h0000_1234);
        txn(0, 0, 1, 32'hF000_0000, 32'h0000_0100);
        cnt_val = 32'h55;
        txn(0, 1, 0, 32'hF000_0000, 32'h0);
        txn(1, 1, 0, 32'h0000_0010, 32'h0);

        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0000_0010; cpu_mio1 = 1'b1;
        pulses = '0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            pulses[n] = mio_ready1;
        end
        cpu_mio1 = 1'b0;
        check("held_pulses", {26'h0, pulses}, 32'b100100);
        check("held_rdata", rdata1, 32'hDEAD_BEEF);

        txn(0, 1, 0, 32'h5000_0000, 32'h0);
        txn(0, 1, 1, 32'h0000_0010, 32'h1111_2222);
        txn(0, 0, 0, 32'hE000_0000, 32'h0);

        for (int k = 0; k < 80; k++) begin
            r  = int'($urandom_range(0, 9));
            rg = r < 4 ? 4'h0 : r < 6 ? 4'hE : r < 8 ? 4'hF : 4'($urandom_range(1, 13));
            op = int'($urandom_range(0, 9));
            gpio_in = 16'($urandom);
            cnt_val = $urandom;
            txn(k % 5 == 4 && rg == 4'h0 && op < 4, op < 4 || op == 8, op >= 4 && op <= 8,
                {rg, 16'($urandom), 6'h0, 4'($urandom), 2'($urandom)}, $urandom);
        end

        txn(0, 0, 1, 32'hE000_0000, 32'h0000_0BAD);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0000_0010; cpu_mio0 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1; cpu_mio0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        events = 0;
        repeat (4) begin
            @(negedge clk);
            events += int'(mio_ready0) + int'(ram_we0) + int'(cnt_we0);
        end
        ref_gpio = '0; ref_err = 1'b0;
        check("abort_events", events, 0);
        check("abort_gpio", gpio_out0, 32'h0);
        check("abort_err", {31'h0, bus_err0}, 32'h0);
        txn(0, 1, 0, 32'h0000_0010, 32'h0);
        txn(0, 0, 1, 32'hE000_0000, 32'h0000_7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
